// File: rtl/apb_master_ctrl.sv
// APB initiator: accepts one read/write command, runs the SETUP/ACCESS
// sequence with an ACCESS-phase timeout and returns data plus status.
module apb_master_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              p_clk_i,
    input  logic              p_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [DATA_W-1:0] cmd_dat_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic              p_sel_o,
    output logic              p_enable_o,
    output logic              p_we_o,
    output logic [ADDR_W-1:0] p_adr_o,
    output logic [DATA_W-1:0] p_dat_o,
    input  logic [DATA_W-1:0] p_dat_i,
    input  logic              p_ready_i
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;
    logic                p_sel_q, p_sel_d;
    logic                p_enable_q, p_enable_d;
    logic                p_we_q, p_we_d;
    logic [ADDR_W-1:0]   p_adr_q, p_adr_d;
    logic [DATA_W-1:0]   p_dat_q, p_dat_d;

    // Next-state and next-output logic; every output is a register image.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        p_sel_d     = p_sel_q;
        p_enable_d  = p_enable_q;
        p_we_d      = p_we_q;
        p_adr_d     = p_adr_q;
        p_dat_d     = p_dat_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    cmd_ready_d = 1'b0;
                    p_sel_d     = 1'b1;
                    p_enable_d  = 1'b0;
                    p_we_d      = cmd_we_i;
                    p_adr_d     = cmd_adr_i;
                    p_dat_d     = cmd_dat_i;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                p_enable_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_ACCESS;
            end
            S_ACCESS: begin
                // Ready wins over timeout on the last allowed cycle.
                if (p_ready_i || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~p_ready_i;
                    rsp_dat_d   = (p_ready_i && !p_we_q) ? p_dat_i : '0;
                    p_sel_d     = 1'b0;
                    p_enable_d  = 1'b0;
                    p_we_d      = 1'b0;
                    p_adr_d     = '0;
                    p_dat_d     = '0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            p_sel_q     <= 1'b0;
            p_enable_q  <= 1'b0;
            p_we_q      <= 1'b0;
            p_adr_q     <= '0;
            p_dat_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            p_sel_q     <= p_sel_d;
            p_enable_q  <= p_enable_d;
            p_we_q      <= p_we_d;
            p_adr_q     <= p_adr_d;
            p_dat_q     <= p_dat_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign p_sel_o     = p_sel_q;
    assign p_enable_o  = p_enable_q;
    assign p_we_o      = p_we_q;
    assign p_adr_o     = p_adr_q;
    assign p_dat_o     = p_dat_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed table, corner sequences and random
// transactions against a CRC8-peripheral model with programmable wait states.
module tb_apb_master_ctrl;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              clk;
    logic              p_rst_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [ADDR_W-1:0] cmd_adr_i;
    logic [DATA_W-1:0] cmd_dat_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_dat_o;
    logic              rsp_err_o;
    logic              p_sel_o;
    logic              p_enable_o;
    logic              p_we_o;
    logic [ADDR_W-1:0] p_adr_o;
    logic [DATA_W-1:0] p_dat_o;
    logic [DATA_W-1:0] p_dat_i;
    logic              p_ready_i;

    apb_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .p_clk_i     (clk),
        .p_rst_i     (p_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .p_sel_o     (p_sel_o),
        .p_enable_o  (p_enable_o),
        .p_we_o      (p_we_o),
        .p_adr_o     (p_adr_o),
        .p_dat_o     (p_dat_o),
        .p_dat_i     (p_dat_i),
        .p_ready_i   (p_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Peripheral configuration shared with the slave process.
    int          slv_wait;
    logic [31:0] slv_rdata;
    logic [7:0]  slv_crc;
    int          acc_n;

    // Reference: bytes successfully written to the CRC data register.
    logic [7:0]  wr_q[$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        int          wt;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_lat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Register-update form used by the peripheral.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // Bit-serial LFSR form over the whole message (x^8+x^2+x+1, init 0).
    function automatic logic [7:0] crc_of(input logic [7:0] q[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (q[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[k][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // APB peripheral: slv_wait wait states, CRC data at 0x0, CRC result at 0x4.
    initial begin
        p_ready_i = 1'b0;
        p_dat_i   = '0;
        acc_n     = 0;
        slv_crc   = 8'h00;
        forever begin
            @(negedge clk);
            if (p_sel_o === 1'b1 && p_enable_o === 1'b1) begin
                p_ready_i = (acc_n >= slv_wait);
                acc_n++;
            end else begin
                p_ready_i = 1'b0;
                acc_n     = 0;
            end
            if (p_ready_i) begin
                if (p_we_o) begin
                    p_dat_i = $urandom;
                    if (p_adr_o == 32'h0) slv_crc = crc_step(slv_crc, p_dat_o[7:0]);
                end else begin
                    p_dat_i = (p_adr_o == 32'h4) ? {24'h0, slv_crc} : slv_rdata;
                end
            end else begin
                p_dat_i = $urandom;
            end
        end
    end

    // Issue one command from a negedge and check the whole transaction.
    task automatic run_txn(input string nm, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input int wt, input int hold,
                           input logic exp_err, input logic [31:0] exp_dat, input int exp_lat);
        int          lat, nsel, nen, guard;
        logic        bus_ok, hold_ok, e0;
        logic [31:0] d0;
        slv_wait    = wt;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        guard = 0;
        while (cmd_ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, " cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        @(negedge clk);
        lat = 0; nsel = 0; nen = 0; bus_ok = 1'b1;
        while (rsp_valid_o !== 1'b1 && lat < 60) begin
            if (p_sel_o === 1'b1) nsel++;
            if (p_enable_o === 1'b1) nen++;
            if (p_adr_o !== adr || p_we_o !== we || p_dat_o !== dat || cmd_ready_o !== 1'b0)
                bus_ok = 1'b0;
            cmd_valid_i = 1'($urandom_range(0, 1));
            cmd_we_i    = 1'($urandom_range(0, 1));
            cmd_adr_i   = $urandom;
            cmd_dat_i   = $urandom;
            rsp_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        rsp_ready_i = 1'b0;
        chk({nm, " rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " sel_cycles"}, 32'(nsel), 32'(exp_lat));
        chk({nm, " enable_cycles"}, 32'(nen), 32'(exp_lat - 1));
        chk({nm, " bus_stable"}, 32'(bus_ok), 32'd1);
        chk({nm, " rsp_err"}, 32'(rsp_err_o), 32'(exp_err));
        chk({nm, " rsp_dat"}, rsp_dat_o, exp_dat);
        chk({nm, " bus_idle"}, 32'({p_sel_o, p_enable_o, p_we_o}) | p_adr_o | p_dat_o, 32'd0);
        e0 = rsp_err_o;
        d0 = rsp_dat_o;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cmd_valid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_err_o !== e0 || rsp_dat_o !== d0 ||
                cmd_ready_o !== 1'b0 || p_sel_o !== 1'b0)
                hold_ok = 1'b0;
        end
        chk({nm, " rsp_hold"}, 32'(hold_ok), 32'd1);
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk({nm, " rsp_done"}, 32'({rsp_valid_o, cmd_ready_o}), 32'b01);
    endtask

    // Wait for a response with a cycle budget.
    task automatic wait_rsp(input string nm);
        int guard;
        guard = 0;
        while (rsp_valid_o !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, " rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  q0[$];
        logic        r_we, r_err;
        logic [31:0] r_adr, r_dat, r_exp;
        int          r_wt, r_hold, r_lat, sel_n;
        logic        ok;

        p_rst_i     = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        rsp_ready_i = 1'b0;
        slv_wait    = 0;
        slv_rdata   = '0;

        q0.push_back(8'hAA);
        q0.push_back(8'h33);
        //            we    adr         dat          rdata        wt   hold err   exp_dat               lat
        tbl[0] = '{1'b1, 32'h0,  32'hAA,       32'h0,       1,   2, 1'b0, 32'h0,                 3};
        tbl[1] = '{1'b1, 32'h0,  32'h33,       32'h0,       0,   0, 1'b0, 32'h0,                 2};
        tbl[2] = '{1'b0, 32'h4,  32'h0,        32'h0,       2,   1, 1'b0, {24'h0, crc_of(q0)},   4};
        tbl[3] = '{1'b0, 32'h8,  32'h0,        32'h12345678, 0,  0, 1'b0, 32'h12345678,          2};
        tbl[4] = '{1'b0, 32'h8,  32'h0,        32'hDEADBEEF, 100, 1, 1'b1, 32'h0,                17};
        tbl[5] = '{1'b0, 32'h8,  32'h0,        32'hCAFEF00D, 15, 0, 1'b0, 32'hCAFEF00D,          17};
        tbl[6] = '{1'b1, 32'hC,  32'h77,       32'h0,       16,  3, 1'b1, 32'h0,                 17};

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        chk("reset cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("reset rsp", 32'({rsp_valid_o, rsp_err_o}) | rsp_dat_o, 32'd0);
        chk("reset bus", 32'({p_sel_o, p_enable_o, p_we_o}) | p_adr_o | p_dat_o, 32'd0);
        p_rst_i = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            slv_rdata = tbl[i].rdata;
            run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].wt,
                    tbl[i].hold, tbl[i].exp_err, tbl[i].exp_dat, tbl[i].exp_lat);
            if (tbl[i].we && tbl[i].adr == 32'h0 && !tbl[i].exp_err) wr_q.push_back(tbl[i].dat[7:0]);
        end

        // Response back-pressure with a command waiting.
        slv_wait    = 0;
        slv_rdata   = 32'h0BADF00D;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h8;
        cmd_dat_i   = 32'h0;
        @(negedge clk);
        cmd_we_i  = 1'b1;
        cmd_adr_i = 32'h10;
        cmd_dat_i = 32'h55;
        wait_rsp("bp first");
        chk("bp first rsp_dat", rsp_dat_o, 32'h0BADF00D);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h0BADF00D || rsp_err_o !== 1'b0 ||
                cmd_ready_o !== 1'b0 || p_sel_o !== 1'b0)
                ok = 1'b0;
        end
        chk("bp hold", 32'(ok), 32'd1);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("bp after hs", 32'({rsp_valid_o, cmd_ready_o, p_sel_o}), 32'b010);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk("bp setup ctl", 32'({p_sel_o, p_enable_o, p_we_o, cmd_ready_o}), 32'b1010);
        chk("bp setup adr", p_adr_o, 32'h10);
        chk("bp setup dat", p_dat_o, 32'h55);
        wait_rsp("bp second");
        chk("bp second rsp", 32'(rsp_err_o) | rsp_dat_o, 32'd0);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;

        // Reset in the middle of ACCESS.
        slv_wait    = 1000;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h20;
        cmd_dat_i   = 32'h0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("rst access enable", 32'(p_enable_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        p_rst_i = 1'b1;
        @(negedge clk);
        p_rst_i = 1'b0;
        chk("rst ctl", 32'({p_sel_o, p_enable_o, rsp_valid_o, cmd_ready_o}), 32'b0001);
        chk("rst adr", p_adr_o, 32'd0);
        sel_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || p_sel_o !== 1'b0) sel_n++;
        end
        chk("rst no partial rsp", 32'(sel_n), 32'd0);
        run_txn("post rst write", 1'b1, 32'h0, 32'h5A, 2, 1, 1'b0, 32'h0, 4);
        wr_q.push_back(8'h5A);

        // Random transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            r_we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       r_adr = 32'h0;
                1:       r_adr = 32'h4;
                2:       r_adr = 32'h8;
                default: r_adr = $urandom & 32'hFFFF_FFFC;
            endcase
            r_dat = $urandom;
            case ($urandom_range(0, 9))
                6:       r_wt = 15;
                7:       r_wt = 16;
                8:       r_wt = 14;
                9:       r_wt = 40;
                default: r_wt = int'($urandom_range(0, 3));
            endcase
            r_hold    = int'($urandom_range(0, 3));
            slv_rdata = $urandom;
            r_err = (r_wt >= int'(TIMEOUT));
            r_lat = 1 + ((r_wt + 1 < int'(TIMEOUT)) ? r_wt + 1 : int'(TIMEOUT));
            if (r_we || r_err)        r_exp = 32'h0;
            else if (r_adr == 32'h4)  r_exp = {24'h0, crc_of(wr_q)};
            else                      r_exp = slv_rdata;
            run_txn($sformatf("rnd%0d", n), r_we, r_adr, r_dat, r_wt, r_hold, r_err, r_exp, r_lat);
            if (r_we && r_adr == 32'h0 && !r_err) wr_q.push_back(r_dat[7:0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
